// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared encodings, FSM states and trap decode for the fetch stage
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [31:0] ECALL_INST  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // True for the two environment-trap encodings that stop fetch.
    function automatic logic is_trap(input logic [31:0] word);
        return (word == ECALL_INST) || (word == EBREAK_INST);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory bus and IF/ID outputs of the fetch stage
interface fetch_unit_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [31:0]       if_inst;
    logic [31:0]       if_pc;
    logic [31:0]       if_pc_plus4;
    logic              if_valid;

    modport master (
        output imem_addr, if_inst, if_pc, if_pc_plus4, if_valid,
        input  imem_data
    );

    modport slave (
        input  imem_addr, if_inst, if_pc, if_pc_plus4, if_valid,
        output imem_data
    );
endinterface

// File: rtl/fetch_unit_ifid_reg.sv
// rtl/fetch_unit_ifid_reg.sv - IF/ID pipeline register with bubble and hold control
module fetch_unit_ifid_reg
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble,
    input  logic        hold,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid
);

    // Bubble beats hold; a bubble keeps the old PC fields so debug views stay stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_inst     <= NOP_INST;
            if_pc       <= 32'd0;
            if_pc_plus4 <= 32'd0;
            if_valid    <= 1'b0;
        end else if (bubble) begin
            if_inst  <= NOP_INST;
            if_valid <= 1'b0;
        end else if (!hold) begin
            if_inst     <= inst;
            if_pc       <= pc;
            if_pc_plus4 <= pc_plus4;
            if_valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: PC, IF/ID register, fetch counter; FETCH_HALT_EN adds trap halt FSM
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ADDR_W      = 6,
    parameter int          PEND_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    fetch_unit_if.master bus,
    output logic [31:0] fetch_count,
    output logic        halted
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        in_pend;
    logic        in_halt;
    logic        bubble;
    logic        hold;
    logic        take;
    logic [1:0]  unused_rpc_lo;

    assign pc_plus4      = pc + 32'd4;
    assign bus.imem_addr = pc[ADDR_W+1:2];
    assign unused_rpc_lo = redirect_pc[1:0];

`ifdef FETCH_HALT_EN
    localparam int CNT_W = (PEND_CYCLES > 1) ? $clog2(PEND_CYCLES) : 1;

    fetch_state_t     state;
    logic [CNT_W-1:0] pend_cnt;

    assign in_pend = (state == ST_PEND);
    assign in_halt = (state == ST_HALT);

    // RUN/PEND/HALT: a latched trap must survive PEND_CYCLES unflushed edges before fetch stops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            pend_cnt <= '0;
            halted   <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (take && is_trap(bus.imem_data)) begin
                        state    <= ST_PEND;
                        pend_cnt <= CNT_W'(PEND_CYCLES - 1);
                    end
                end
                ST_PEND: begin
                    if (redirect || flush) begin
                        state <= ST_RUN;
                    end else if (!stall) begin
                        if (pend_cnt == '0) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end else begin
                            pend_cnt <= pend_cnt - 1'b1;
                        end
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_RUN;
            endcase
        end
    end
`else
    logic [31:0] unused_pend_cycles;

    assign unused_pend_cycles = PEND_CYCLES;
    assign in_pend = 1'b0;
    assign in_halt = 1'b0;
    assign halted  = 1'b0;
`endif

    // Once halted everything but reset is ignored; in PEND only the stall holds IF/ID.
    assign bubble = in_halt || redirect || flush || (in_pend && !stall);
    assign hold   = !bubble && stall;
    assign take   = !bubble && !stall;

    // PC priority: reset, redirect (word-aligned), stall or trap freeze, sequential.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (in_halt) begin
            pc <= pc;
        end else if (redirect) begin
            pc <= {redirect_pc[31:2], 2'b00};
        end else if (!(stall || in_pend)) begin
            pc <= pc_plus4;
        end
    end

    // Counts only instructions that enter IF/ID as valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= 32'd0;
        end else if (take) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    fetch_unit_ifid_reg u_ifid_reg (
        .clk         (clk),
        .rst         (rst),
        .bubble      (bubble),
        .hold        (hold),
        .inst        (bus.imem_data),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .if_inst     (bus.if_inst),
        .if_pc       (bus.if_pc),
        .if_pc_plus4 (bus.if_pc_plus4),
        .if_valid    (bus.if_valid)
    );

endmodule
